// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared types, default widths and address helpers for cache_ctrl
package cache_pkg;

    localparam int IDX_W  = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = IDX_W + TAG_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        FILL   = 2'd3
    } state_t;

    // Addresses are {tag, index} with the index in the LSBs.
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - CPU, backing-memory, SRAM and statistics signals of cache_ctrl
interface cache_ctrl_if #(
    parameter int IDX_W  = cache_pkg::IDX_W,
    parameter int TAG_W  = cache_pkg::TAG_W,
    parameter int DATA_W = cache_pkg::DATA_W,
    parameter int CNT_W  = cache_pkg::CNT_W
);
    logic                   req_valid;
    logic [IDX_W+TAG_W-1:0] req_addr;
    logic                   req_ready;
    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_hit;
    logic                   flush;
    logic                   mem_req;
    logic [IDX_W+TAG_W-1:0] mem_addr;
    logic                   mem_ack;
    logic [DATA_W-1:0]      mem_rdata;
    logic [2**IDX_W-1:0]    sram_wl;
    logic                   sram_we;
    logic [TAG_W-1:0]       sram_tag_in;
    logic [DATA_W-1:0]      sram_data_in;
    logic [TAG_W-1:0]       sram_tag_out;
    logic [DATA_W-1:0]      sram_data_out;
    logic [CNT_W-1:0]       hit_cnt;
    logic [CNT_W-1:0]       miss_cnt;

    modport master (
        input  req_valid, req_addr, flush, mem_ack, mem_rdata, sram_tag_out, sram_data_out,
        output req_ready, rsp_valid, rsp_data, rsp_hit, mem_req, mem_addr,
               sram_wl, sram_we, sram_tag_in, sram_data_in, hit_cnt, miss_cnt
    );

    modport slave (
        output req_valid, req_addr, flush, mem_ack, mem_rdata, sram_tag_out, sram_data_out,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, mem_req, mem_addr,
               sram_wl, sram_we, sram_tag_in, sram_data_in, hit_cnt, miss_cnt
    );

endinterface

// File: rtl/cache_ctrl_sat_counter.sv
// rtl/cache_ctrl_sat_counter.sv - saturating up-counter used for hit/miss statistics
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped read cache controller sequencing an external tag/data SRAM
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int IDX_W  = cache_pkg::IDX_W,
    parameter int TAG_W  = cache_pkg::TAG_W,
    parameter int DATA_W = cache_pkg::DATA_W,
    parameter int CNT_W  = cache_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_ctrl_if.master bus
);

    localparam int LINES = 2**IDX_W;
    localparam int AW    = IDX_W + TAG_W;

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_addr;
    logic [DATA_W-1:0]   r_fill;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_valid;
    logic                r_rsp_hit;
    logic                r_flush_pend;
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_sram_wl;
    logic                r_sram_we;
    logic                r_mem_req;
    logic [LINES-1:0]    w_wl_next;
    logic                w_we_next;
    logic                w_mem_req_next;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_hit;
    logic                w_hit_inc;
    logic                w_miss_inc;
    logic                w_flush_clr;
    logic [CNT_W-1:0]    w_hit_cnt;
    logic [CNT_W-1:0]    w_miss_cnt;

    assign w_req_ready = (r_state == IDLE) && !bus.flush && !r_flush_pend;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_hit       = r_valid[idx_of(r_addr)] && (bus.sram_tag_out == tag_of(r_addr));
    assign w_hit_inc   = (r_state == LOOKUP) && w_hit;
    assign w_miss_inc  = (r_state == LOOKUP) && !w_hit;
    assign w_flush_clr = (r_state == IDLE) && r_flush_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = LOOKUP;
            LOOKUP:  w_next = w_hit ? IDLE : MISS;
            MISS:    if (bus.mem_ack) w_next = FILL;
            FILL:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // SRAM and memory strobes are decoded from the next state and registered,
    // so LOOKUP sees the wordline of the address accepted at the entry edge.
    always_comb begin
        w_wl_next      = '0;
        w_we_next      = 1'b0;
        w_mem_req_next = 1'b0;
        case (w_next)
            LOOKUP: w_wl_next = LINES'(1) << idx_of(bus.req_addr);
            MISS:   w_mem_req_next = 1'b1;
            FILL: begin
                w_wl_next = LINES'(1) << idx_of(r_addr);
                w_we_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sram_wl <= '0;
            r_sram_we <= 1'b0;
            r_mem_req <= 1'b0;
        end else begin
            r_sram_wl <= w_wl_next;
            r_sram_we <= w_we_next;
            r_mem_req <= w_mem_req_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_fill      <= '0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_addr <= bus.req_addr;
            end
            if ((r_state == MISS) && bus.mem_ack) begin
                r_fill <= bus.mem_rdata;
            end
            if (w_hit_inc) begin
                r_rsp_data  <= bus.sram_data_out;
                r_rsp_hit   <= 1'b1;
                r_rsp_valid <= 1'b1;
            end else if (r_state == FILL) begin
                r_rsp_data  <= r_fill;
                r_rsp_hit   <= 1'b0;
                r_rsp_valid <= 1'b1;
            end
        end
    end

    // A new flush pulse takes priority so a pulse landing on the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_pend <= 1'b0;
        end else if (bus.flush) begin
            r_flush_pend <= 1'b1;
        end else if (w_flush_clr) begin
            r_flush_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_flush_clr) begin
            r_valid <= '0;
        end else if (r_state == FILL) begin
            r_valid[idx_of(r_addr)] <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_hit_inc),
        .cnt   (w_hit_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_miss_inc),
        .cnt   (w_miss_cnt)
    );

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_hit      = r_rsp_hit;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_addr     = r_addr;
    assign bus.sram_wl      = r_sram_wl;
    assign bus.sram_we      = r_sram_we;
    assign bus.sram_tag_in  = tag_of(r_addr);
    assign bus.sram_data_in = r_fill;
    assign bus.hit_cnt      = w_hit_cnt;
    assign bus.miss_cnt     = w_miss_cnt;

endmodule
